alu_arbiter: RTL and testbench

Shares one 32-bit integer ALU between two requesters (e.g. the execute stage and a multiply/shift helper) using a valid/ready request handshake and a one-cycle response pulse. Round-robin arbitration among the requesters, one operation in flight at a time, with multiply taking a configurable multi-cycle latency and all other operations taking one cycle. The block sits beside the execute stage and owns the ALU operation encoding.

---
 rtl/alu_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one 32-bit integer ALU between two requesters. Each requester
//   presents an operation with a valid/ready handshake. Arbitration is
//   round-robin, and only one operation is in flight at a time. Multiply
//   takes MUL_LAT cycles from accept to response. Every other operation,
//   including an unsupported opcode, takes one cycle. Results come back as a
//   one-cycle valid pulse on the accepted requester's response port.
//
// Parameters
//   MUL_LAT        cycles from accept to response for multiply (1..15)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   reqN_valid_i   requester N has an operation pending
//   reqN_ready_o   requester N is accepted this cycle (combinational)
//   reqN_ctrl_i    requester N operation code
//   reqN_data1_i   requester N operand 1
//   reqN_data2_i   requester N operand 2
//   rspN_valid_o   one-cycle result pulse for requester N
//   rspN_data_o    result for requester N, held until its next response
//   rspN_err_o     unsupported opcode flag, held like rspN_data_o
module alu_arbiter #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [3:0]  req0_ctrl_i,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [3:0]  req1_ctrl_i,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_data_o,
  output logic        rsp0_err_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_data_o,
  output logic        rsp1_err_o
);

  // ALU operation encoding
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;

  // The counter starts at L-1. The response fires on the cycle the counter
  // would reach zero, so it lands exactly L cycles after the accept.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
  localparam bit         MUL_MULTI    = (MUL_LAT > 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;        // requester granted most recently
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_err_q, pend_err_d;
  logic        pend_id_q, pend_id_d;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic       grant_id;
  logic       can_accept;
  logic       transfer;

  assign req_valid  = {req1_valid_i, req0_valid_i};
  assign can_accept = (state_q == ST_IDLE) && !rst_i;

  // On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last_q;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = can_accept && req_valid[gi] && (grant_id == (gi == 1));
    end
  endgenerate

  assign req0_ready_o = req_ready[0];
  assign req1_ready_o = req_ready[1];
  assign transfer     = |req_ready;

  // ---------------------------------------------------------------------
  // Shared ALU, fed by the granted requester's operands
  // ---------------------------------------------------------------------
  logic [3:0]  op_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] mul_lo;
  logic [31:0] sra_res;
  logic [31:0] alu_res;
  logic        alu_err;
  logic        alu_multi;

  assign op_ctrl = grant_id ? req1_ctrl_i  : req0_ctrl_i;
  assign op_a    = grant_id ? req1_data1_i : req0_data1_i;
  assign op_b    = grant_id ? req1_data2_i : req0_data2_i;

  // The low 32 bits of a two's-complement product are the same whether the
  // operands are treated as signed or unsigned. A 32-bit product is enough.
  assign mul_lo  = op_a * op_b;
  assign sra_res = $unsigned($signed(op_a) >>> op_b[4:0]);

  always_comb begin
    alu_res = 32'd0;
    alu_err = 1'b0;
    case (op_ctrl)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_MUL:  alu_res = mul_lo;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRA:  alu_res = sra_res;
      OP_SLL:  alu_res = op_a << op_b[4:0];
      OP_AND:  alu_res = op_a & op_b;
      default: alu_err = 1'b1;
    endcase
  end

  // With MUL_LAT of 1, multiply completes in one cycle like any other
  // operation.
  assign alu_multi = MUL_MULTI && (op_ctrl == OP_MUL);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  logic        fire;
  logic        fire_id;
  logic [31:0] fire_data;
  logic        fire_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;             // requester 0 wins the first tie
      pend_data_q <= 32'd0;
      pend_err_q  <= 1'b0;
      pend_id_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      pend_data_q <= pend_data_d;
      pend_err_q  <= pend_err_d;
      pend_id_q   <= pend_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    pend_data_d = pend_data_q;
    pend_err_d  = pend_err_q;
    pend_id_d   = pend_id_q;
    fire        = 1'b0;
    fire_id     = grant_id;
    fire_data   = alu_res;
    fire_err    = alu_err;

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          last_d = grant_id;
          if (alu_multi) begin
            // Park the result until the latency has elapsed.
            state_d     = ST_BUSY;
            cnt_d       = MUL_CNT_INIT;
            pend_data_d = alu_res;
            pend_err_d  = alu_err;
            pend_id_d   = grant_id;
          end else begin
            fire = 1'b1;
          end
        end
      end

      ST_BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d   = ST_IDLE;
          cnt_d     = 4'd0;
          fire      = 1'b1;
          fire_id   = pend_id_q;
          fire_data = pend_data_q;
          fire_err  = pend_err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Per-requester response registers. Data and err only change when that
  // port receives a response, so a result stays readable after its pulse.
  // ---------------------------------------------------------------------
  logic        rsp_valid_q [2];
  logic [31:0] rsp_data_q  [2];
  logic        rsp_err_q   [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic hit;
      assign hit = fire && (fire_id == (gi == 1));

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rsp_valid_q[gi] <= 1'b0;
          rsp_data_q[gi]  <= 32'd0;
          rsp_err_q[gi]   <= 1'b0;
        end else begin
          rsp_valid_q[gi] <= hit;
          if (hit) begin
            rsp_data_q[gi] <= fire_data;
            rsp_err_q[gi]  <= fire_err;
          end
        end
      end
    end
  endgenerate

  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp0_data_o  = rsp_data_q[0];
  assign rsp0_err_o   = rsp_err_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp1_data_o  = rsp_data_q[1];
  assign rsp1_err_o   = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random stimulus for alu_arbiter with MUL_LAT = 3.
// Expected responses are computed from the operation table and queued per
// port with their due cycle. Each cycle, the bench pops the entry that is due
// and compares it with what the DUT produced.
module tb_alu_arbiter;
  localparam int unsigned MUL_LAT = 3;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_BAD = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [3:0]  req0_ctrl_i, req1_ctrl_i;
  logic [31:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic [31:0] rsp0_data_o, rsp1_data_o;
  logic        rsp0_err_o, rsp1_err_o;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_ctrl_i  (req0_ctrl_i),
    .req0_data1_i (req0_data1_i),
    .req0_data2_i (req0_data2_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_ctrl_i  (req1_ctrl_i),
    .req1_data1_i (req1_data1_i),
    .req1_data2_i (req1_data2_i),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp0_data_o  (rsp0_data_o),
    .rsp0_err_o   (rsp0_err_o),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp1_data_o  (rsp1_data_o),
    .rsp1_err_o   (rsp1_err_o)
  );

  logic [1:0]  rsp_v;
  logic [31:0] rsp_d [2];
  logic [1:0]  rsp_e;
  assign rsp_v    = {rsp1_valid_o, rsp0_valid_o};
  assign rsp_d[0] = rsp0_data_o;
  assign rsp_d[1] = rsp1_data_o;
  assign rsp_e    = {rsp1_err_o, rsp0_err_o};

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          free_cyc = 0;
  logic        last = 1'b1;
  logic        g0, g1;
  logic [31:0] hold_d [2];
  logic        hold_e [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // Reference results taken directly from the operation table.
  task automatic golden(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e);
    logic signed [31:0] sa;
    sa = a;
    e  = 1'b0;
    case (c)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_XOR:  r = a ^ b;
      OP_SRA:  r = sa >>> b[4:0];
      OP_SLL:  r = a << b[4:0];
      OP_AND:  r = a & b;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endtask

  task automatic check_rsp();
    exp_t e;
    logic ev;
    for (int p = 0; p < 2; p++) begin
      ev = 1'b0;
      if (p == 0) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin ev = 1'b1; e = q0.pop_front(); end
      end else begin
        if (q1.size() > 0 && q1[0].due == cyc) begin ev = 1'b1; e = q1.pop_front(); end
      end
      if (ev) begin
        hold_d[p] = e.data;
        hold_e[p] = e.err;
      end
      chk($sformatf("rsp%0d_valid", p), {31'd0, rsp_v[p]}, {31'd0, ev});
      chk($sformatf("rsp%0d_data", p), rsp_d[p], hold_d[p]);
      chk($sformatf("rsp%0d_err", p), {31'd0, rsp_e[p]}, {31'd0, hold_e[p]});
    end
    $display("cyc %0d rsp0 v=%0b d=%h e=%0b rsp1 v=%0b d=%h e=%0b",
             cyc, rsp_v[0], rsp_d[0], rsp_e[0], rsp_v[1], rsp_d[1], rsp_e[1]);
  endtask

  // One clock cycle. Inputs were driven just after the previous edge.
  // This task checks ready mid-cycle, records any expected transfer, then
  // crosses the edge and checks the responses.
  task automatic step();
    logic        e0, e1;
    logic [31:0] r;
    logic        er;
    int          lat;
    exp_t        ent;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst_i && cyc >= free_cyc) begin
      if (req0_valid_i && req1_valid_i) begin
        if (last) e0 = 1'b1; else e1 = 1'b1;
      end else if (req0_valid_i) begin
        e0 = 1'b1;
      end else if (req1_valid_i) begin
        e1 = 1'b1;
      end
    end
    chk("req0_ready", {31'd0, req0_ready_o}, {31'd0, e0});
    chk("req1_ready", {31'd0, req1_ready_o}, {31'd0, e1});
    g0 = e0;
    g1 = e1;
    if (e0 || e1) begin
      if (e0) golden(req0_ctrl_i, req0_data1_i, req0_data2_i, r, er);
      else    golden(req1_ctrl_i, req1_data1_i, req1_data2_i, r, er);
      lat = ((e0 ? req0_ctrl_i : req1_ctrl_i) == OP_MUL) ? int'(MUL_LAT) : 1;
      ent.data = r;
      ent.err  = er;
      ent.due  = cyc + lat;
      if (e0) q0.push_back(ent); else q1.push_back(ent);
      last     = e1;
      free_cyc = cyc + lat;
      $display("cyc %0d grant %0d ctrl=%b due=%0d", cyc, e1, e0 ? req0_ctrl_i : req1_ctrl_i, ent.due);
    end
    if (rst_i) begin
      q0.delete();
      q1.delete();
      last     = 1'b1;
      free_cyc = cyc + 1;
      for (int p = 0; p < 2; p++) begin
        hold_d[p] = 32'd0;
        hold_e[p] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_rsp();
  endtask

  // Step, then withdraw each request that was just accepted.
  task automatic step_auto();
    step();
    if (g0) req0_valid_i = 1'b0;
    if (g1) req1_valid_i = 1'b0;
  endtask

  task automatic set0(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req0_valid_i = 1'b1; req0_ctrl_i = c; req0_data1_i = a; req0_data2_i = b;
  endtask

  task automatic set1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req1_valid_i = 1'b1; req1_ctrl_i = c; req1_data1_i = a; req1_data2_i = b;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step_auto();
  endtask

  logic [3:0] op_tab [8];

  initial begin
    op_tab = '{OP_AND, OP_SLL, OP_ADD, OP_SRA, OP_SUB, OP_XOR, OP_MUL, OP_BAD};
    for (int p = 0; p < 2; p++) begin
      hold_d[p] = 32'd0;
      hold_e[p] = 1'b0;
    end
    rst_i = 1'b1;
    req0_valid_i = 1'b0; req0_ctrl_i = 4'd0; req0_data1_i = 32'd0; req0_data2_i = 32'd0;
    req1_valid_i = 1'b0; req1_ctrl_i = 4'd0; req1_data1_i = 32'd0; req1_data2_i = 32'd0;

    // Reset: ready must stay low even while requesters are valid.
    set0(OP_ADD, 32'd1, 32'd2);
    set1(OP_ADD, 32'd3, 32'd4);
    step();
    step();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    rst_i = 1'b0;
    step();

    // Single add: 5 + (-7) = -2, with the response one cycle later on port 0.
    set0(OP_ADD, 32'd5, -32'sd7);
    step_auto();
    drain(2);

    // Multiply 0x10000 * 0x10000 wraps to 0. A competing request must wait.
    set1(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    step_auto();
    set0(OP_SUB, 32'd10, 32'd20);
    drain(5);

    // Round-robin with both requesters continuously valid.
    for (int i = 0; i < 6; i++) begin
      if (!req0_valid_i) set0(OP_AND, $urandom, $urandom);
      if (!req1_valid_i) set1(OP_AND, $urandom, $urandom);
      step_auto();
    end
    drain(3);

    // Shifts and an unsupported opcode.
    set0(OP_SRA, 32'h8000_0000, 32'h0000_0021);
    step_auto();
    set0(OP_SLL, 32'h0000_0001, 32'd31);
    step_auto();
    set0(OP_BAD, 32'h1234_5678, 32'h9abc_def0);
    step_auto();
    drain(2);

    // Reset during a multiply: no response pulse, and req0 wins the next tie.
    set0(OP_MUL, 32'd7, 32'd9);
    step_auto();
    step_auto();
    rst_i = 1'b1;
    step_auto();
    rst_i = 1'b0;
    set0(OP_XOR, 32'hff00_ff00, 32'h0ff0_0ff0);
    set1(OP_ADD, 32'd100, 32'd200);
    step_auto();
    drain(4);

    // Back-to-back single-cycle ops from one requester.
    set0(OP_ADD, 32'h7fff_ffff, 32'd1);
    step_auto();
    set0(OP_XOR, 32'haaaa_5555, 32'h5555_aaaa);
    step_auto();
    drain(2);

    // Random mix. Requests hold until accepted, and an ungranted request is
    // sometimes withdrawn.
    for (int i = 0; i < 40; i++) begin
      if (!req0_valid_i && $urandom_range(0, 1) == 1)
        set0(op_tab[$urandom_range(0, 7)], $urandom, $urandom);
      else if (req0_valid_i && $urandom_range(0, 7) == 0)
        req0_valid_i = 1'b0;
      if (!req1_valid_i && $urandom_range(0, 1) == 1)
        set1(op_tab[$urandom_range(0, 7)], $urandom, $urandom);
      step_auto();
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    drain(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
